// File: rtl/life_gen_ctrl.sv
// Generation controller for the Game-of-Life cell array: pattern load, single-step,
// free-run at a programmable interval, generation counting and stable-board halt.
module life_gen_ctrl #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned GEN_W = 16,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned RS_W  = 3
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_stop,
    input  logic             cmd_step,
    input  logic [DIV_W-1:0] period,
    input  logic             load_valid,
    input  logic [COLS-1:0]  load_data,
    input  logic             grid_changed,
    output logic             load_ready,
    output logic [RS_W-1:0]  row_sel,
    output logic             row_we,
    output logic             gen_en,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state,
    output logic             stable
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [RS_W-1:0] LAST_ROW = RS_W'(ROWS - 1);

    state_e             state_q, state_d;
    logic [RS_W-1:0]    row_ptr_q, row_ptr_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [GEN_W-1:0]   gen_count_q, gen_count_d;
    logic               stable_q, stable_d;
    logic               gen_en_q, gen_en_d;

    logic [DIV_W-1:0]   per_m1;
    logic               run_due;
    logic               row_hs;
    logic               unused_load_data;

    // Row data goes straight to the array; only the handshake is seen here.
    assign unused_load_data = ^load_data;

    // A period of 0 behaves like 1; >= lets a shortened period fire at once.
    assign per_m1  = (period == '0) ? '0 : period - DIV_W'(1);
    assign run_due = (cnt_q >= per_m1);

    assign load_ready = (state_q == S_LOAD);
    assign row_hs     = load_ready & load_valid & ~cmd_stop;
    assign row_we     = row_hs;
    assign row_sel    = row_ptr_q;

    assign gen_en    = gen_en_q;
    assign gen_count = gen_count_q;
    assign state     = state_q;
    assign stable    = stable_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= S_IDLE;
            row_ptr_q   <= '0;
            cnt_q       <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            gen_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            cnt_q       <= cnt_d;
            gen_count_q <= gen_count_d;
            stable_q    <= stable_d;
            gen_en_q    <= gen_en_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_load) begin
                    state_d = S_LOAD;
                end else if (!cmd_step && cmd_run) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (load_valid && row_ptr_q == LAST_ROW) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (run_due && !grid_changed) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row pointer, interval counter, generation counter and strobe
    always_comb begin
        row_ptr_d   = row_ptr_q;
        cnt_d       = cnt_q;
        gen_count_d = gen_count_q;
        stable_d    = stable_q;
        gen_en_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_load) begin
                    row_ptr_d   = '0;
                    gen_count_d = '0;
                    stable_d    = 1'b0;
                end else if (cmd_step) begin
                    if (grid_changed) begin
                        gen_en_d    = 1'b1;
                        gen_count_d = gen_count_q + GEN_W'(1);
                        stable_d    = 1'b0;
                    end else begin
                        stable_d = 1'b1;
                    end
                end else if (cmd_run) begin
                    cnt_d    = '0;
                    stable_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (cmd_stop) begin
                    row_ptr_d = '0;
                end else if (row_hs) begin
                    row_ptr_d = (row_ptr_q == LAST_ROW) ? '0 : row_ptr_q + RS_W'(1);
                end
            end
            S_RUN: begin
                if (!cmd_stop) begin
                    if (run_due) begin
                        cnt_d = '0;
                        if (grid_changed) begin
                            gen_en_d    = 1'b1;
                            gen_count_d = gen_count_q + GEN_W'(1);
                        end else begin
                            stable_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl: load, step, run, stop, stable halt and async reset.
module tb_life_gen_ctrl;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned GEN_W = 16;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned RS_W  = 3;

    logic             clk;
    logic             _rst;
    logic             cmd_load, cmd_run, cmd_stop, cmd_step;
    logic [DIV_W-1:0] period;
    logic             load_valid;
    logic [COLS-1:0]  load_data;
    logic             grid_changed;
    logic             load_ready;
    logic [RS_W-1:0]  row_sel;
    logic             row_we;
    logic             gen_en;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       state;
    logic             stable;

    int n_checks = 0;
    int n_pass   = 0;

    life_gen_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .DIV_W(DIV_W), .RS_W(RS_W)
    ) dut (
        .clk(clk), ._rst(_rst),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
        .period(period), .load_valid(load_valid), .load_data(load_data),
        .grid_changed(grid_changed), .load_ready(load_ready), .row_sel(row_sel),
        .row_we(row_we), .gen_en(gen_en), .gen_count(gen_count), .state(state),
        .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmds();
        cmd_load = 1'b0;
        cmd_run  = 1'b0;
        cmd_stop = 1'b0;
        cmd_step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt;
        _rst = 1'b0;
        clr_cmds();
        period       = 16'd1;
        load_valid   = 1'b0;
        load_data    = '0;
        grid_changed = 1'b0;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gen_en", 32'(gen_en), 32'd0);
        chk("rst_gen_count", 32'(gen_count), 32'd0);
        chk("rst_stable", 32'(stable), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_row_we", 32'(row_we), 32'd0);
        chk("rst_row_sel", 32'(row_sel), 32'd0);
        _rst = 1'b1;
        tick();

        // Gapped load of 8 rows
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("load_state", 32'(state), 32'd1);
        chk("load_ready", 32'(load_ready), 32'd1);
        we_cnt = 0;
        for (int r = 0; r < 8; r++) begin
            load_valid = 1'b0;
            #1;
            chk("gap_row_we", 32'(row_we), 32'd0);
            if (row_we) we_cnt++;
            tick();
            load_valid = 1'b1;
            load_data  = 8'(8'hA5 ^ 8'(r));
            #1;
            chk("load_row_we", 32'(row_we), 32'd1);
            chk("load_row_sel", 32'(row_sel), 32'(r));
            if (row_we) we_cnt++;
            tick();
            chk("load_state_after_row", 32'(state), (r == 7) ? 32'd0 : 32'd1);
        end
        load_valid = 1'b0;
        chk("load_we_total", 32'(we_cnt), 32'd8);
        chk("load_gen_count", 32'(gen_count), 32'd0);

        // Aborted load: stop discards the coincident row
        cmd_load = 1'b1;
        tick();
        cmd_load   = 1'b0;
        load_valid = 1'b1;
        for (int r = 0; r < 3; r++) tick();
        chk("abort_row_sel", 32'(row_sel), 32'd3);
        cmd_stop = 1'b1;
        #1;
        chk("abort_row_we", 32'(row_we), 32'd0);
        tick();
        cmd_stop   = 1'b0;
        load_valid = 1'b0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd0);
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("reload_row_sel", 32'(row_sel), 32'd0);
        chk("reload_state", 32'(state), 32'd1);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;

        // RUN period=3: strobes after edges 3,6,9; stop at edge 12
        period       = 16'd3;
        grid_changed = 1'b1;
        cmd_run      = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("run3_state", 32'(state), 32'd2);
        chk("run3_stable", 32'(stable), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("run3_gen_en", 32'(gen_en), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("run3_gen_count", 32'(gen_count), 32'(k / 3));
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("run3_stop_gen_en", 32'(gen_en), 32'd0);
        chk("run3_stop_gen_count", 32'(gen_count), 32'd3);
        chk("run3_stop_state", 32'(state), 32'd0);

        // RUN period=2: board goes stable before edge 6
        period  = 16'd2;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) grid_changed = 1'b0;
            tick();
            chk("run2_gen_en", 32'(gen_en), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        tick();
        chk("stable_gen_en", 32'(gen_en), 32'd0);
        chk("stable_flag", 32'(stable), 32'd1);
        chk("stable_state", 32'(state), 32'd0);
        chk("stable_gen_count", 32'(gen_count), 32'd5);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("rerun_stable", 32'(stable), 32'd0);
        chk("rerun_state", 32'(state), 32'd2);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("rerun_stop_state", 32'(state), 32'd0);
        chk("rerun_stop_gen_count", 32'(gen_count), 32'd5);

        // Single steps and command priority in IDLE
        grid_changed = 1'b1;
        cmd_step     = 1'b1;
        tick();
        cmd_step = 1'b0;
        chk("step_gen_en", 32'(gen_en), 32'd1);
        chk("step_gen_count", 32'(gen_count), 32'd6);
        chk("step_state", 32'(state), 32'd0);
        tick();
        chk("step_gen_en_drop", 32'(gen_en), 32'd0);
        grid_changed = 1'b0;
        cmd_step     = 1'b1;
        tick();
        cmd_step = 1'b0;
        chk("step_nochg_gen_en", 32'(gen_en), 32'd0);
        chk("step_nochg_stable", 32'(stable), 32'd1);
        chk("step_nochg_gen_count", 32'(gen_count), 32'd6);
        grid_changed = 1'b1;
        cmd_load     = 1'b1;
        cmd_step     = 1'b1;
        cmd_run      = 1'b1;
        tick();
        clr_cmds();
        chk("prio_state", 32'(state), 32'd1);
        chk("prio_gen_en", 32'(gen_en), 32'd0);
        chk("prio_gen_count", 32'(gen_count), 32'd0);
        chk("prio_stable", 32'(stable), 32'd0);
        cmd_run  = 1'b1;
        cmd_step = 1'b1;
        tick();
        clr_cmds();
        chk("load_ignores_run", 32'(state), 32'd1);
        chk("load_ignores_step", 32'(gen_en), 32'd0);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;

        // period=0 acts as 1: strobe every cycle
        period  = 16'd0;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("p0_gen_en", 32'(gen_en), 32'd1);
            chk("p0_gen_count", 32'(gen_count), 32'(k));
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("p0_stop_gen_en", 32'(gen_en), 32'd0);

        // Async reset mid-RUN with period=4 after two strobes
        period  = 16'd4;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        chk("pre_rst_gen_en", 32'(gen_en), 32'd1);
        chk("pre_rst_gen_count", 32'(gen_count), 32'd5);
        #2;
        _rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_gen_en", 32'(gen_en), 32'd0);
        chk("mid_rst_gen_count", 32'(gen_count), 32'd0);
        #2;
        _rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_gen_en", 32'(gen_en), 32'd0);
            chk("post_rst_state", 32'(state), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
